// File: rtl/mmu_pkg.sv
// ============================================================================
// Module : mmu_pkg
// Brief  : Shared types, constants and mask helper for the ping-pong MMU buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mmu_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2
    } bank_state_t;

    localparam int NUM_BANKS = 2;

    // Upper bound on DEPTH; callers cast the result down to their own WIDTH.
    localparam int MAX_DEPTH = 10;
    localparam int MAX_WIDTH = 2**MAX_DEPTH;

    function automatic logic [MAX_WIDTH-1:0] onehot(input logic [MAX_DEPTH-1:0] addr);
        logic [MAX_WIDTH-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmu_bank.sv
// ============================================================================
// Module : mmu_bank
// Brief  : One buffer bank: storage, write/read coverage masks, EMPTY/LOAD/FULL FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmu_bank
    import mmu_pkg::*;
#(
    parameter int BITWIDTH = 24,
    parameter int DEPTH    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DEPTH-1:0]    wr_addr,
    input  logic [BITWIDTH-1:0] wr_data,
    input  logic                rd_en,
    input  logic [DEPTH-1:0]    rd_addr,
    output logic [BITWIDTH-1:0] rd_data,
    output bank_state_t         state,
    output logic                fill_done,
    output logic                drain_done
);

    localparam int WIDTH = 2**DEPTH;

    bank_state_t         r_state, w_state_nx;
    logic [WIDTH-1:0]    r_wmask, r_rmask;
    logic [WIDTH-1:0]    w_wmask_nx, w_rmask_nx;
    logic [WIDTH-1:0]    w_wmask_upd, w_rmask_upd;
    logic                w_mem_we;
    logic [BITWIDTH-1:0] r_mem [WIDTH];

    assign w_wmask_upd = r_wmask | WIDTH'(onehot(MAX_DEPTH'(wr_addr)));
    assign w_rmask_upd = r_rmask | WIDTH'(onehot(MAX_DEPTH'(rd_addr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_wmask <= '0;
            r_rmask <= '0;
        end else begin
            r_state <= w_state_nx;
            r_wmask <= w_wmask_nx;
            r_rmask <= w_rmask_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_wmask_nx = r_wmask;
        w_rmask_nx = r_rmask;
        w_mem_we   = 1'b0;
        fill_done  = 1'b0;
        drain_done = 1'b0;
        case (r_state)
            EMPTY, LOAD: begin
                if (wr_en) begin
                    w_mem_we = 1'b1;
                    if (&w_wmask_upd) begin
                        w_state_nx = FULL;
                        w_wmask_nx = '0;
                        fill_done  = 1'b1;
                    end else begin
                        w_state_nx = LOAD;
                        w_wmask_nx = w_wmask_upd;
                    end
                end
            end
            FULL: begin
                if (rd_en) begin
                    if (&w_rmask_upd) begin
                        w_state_nx = EMPTY;
                        w_rmask_nx = '0;
                        drain_done = 1'b1;
                    end else begin
                        w_rmask_nx = w_rmask_upd;
                    end
                end
            end
            default: begin
                // Corrupted encoding: recover to a clean empty bank.
                w_state_nx = EMPTY;
                w_wmask_nx = '0;
                w_rmask_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) r_mem[i] <= '0;
        end else if (w_mem_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];
    assign state   = r_state;

endmodule

`default_nettype wire

// File: rtl/mmu_pingpong_buf.sv
// ============================================================================
// Module : mmu_pingpong_buf
// Brief  : Two-bank ping-pong staging buffer between WTU producer and MAC array.
//          Optional sticky error flags when MMU_PP_ERR_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmu_pingpong_buf
    import mmu_pkg::*;
#(
    parameter int BITWIDTH = 24,
    parameter int DEPTH    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DEPTH-1:0]           in_addr,
    input  logic signed [BITWIDTH-1:0] in_data,
    output logic                       in_ready,
    input  logic                       rd_en,
    input  logic [DEPTH-1:0]           out_addr,
    output logic signed [BITWIDTH-1:0] out_data,
    output logic                       out_ready,
    output logic                       out_bank
`ifdef MMU_PP_ERR_EN
    ,
    output logic [1:0]                 err
`endif
);

    logic                 r_wr_bank, r_rd_bank;
    logic                 w_wr_fire, w_rd_fire;
    bank_state_t          w_state   [NUM_BANKS];
    logic [BITWIDTH-1:0]  w_rd_data [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_fill_done, w_drain_done;

    assign in_ready  = (w_state[r_wr_bank] != FULL);
    assign out_ready = (w_state[r_rd_bank] == FULL);
    assign out_bank  = r_rd_bank;
    assign out_data  = w_rd_data[r_rd_bank];
    assign w_wr_fire = wr_en & in_ready;
    assign w_rd_fire = rd_en & out_ready;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mmu_bank #(
            .BITWIDTH (BITWIDTH),
            .DEPTH    (DEPTH)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (w_wr_fire && (r_wr_bank == 1'(g))),
            .wr_addr    (in_addr),
            .wr_data    (in_data),
            .rd_en      (w_rd_fire && (r_rd_bank == 1'(g))),
            .rd_addr    (out_addr),
            .rd_data    (w_rd_data[g]),
            .state      (w_state[g]),
            .fill_done  (w_fill_done[g]),
            .drain_done (w_drain_done[g])
        );
    end

    // Pointers advance independently, so a fill and a drain in one cycle both land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            r_wr_bank <= r_wr_bank ^ (|w_fill_done);
            r_rd_bank <= r_rd_bank ^ (|w_drain_done);
        end
    end

`ifdef MMU_PP_ERR_EN
    logic [1:0] r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 2'b00;
        end else begin
            r_err <= r_err | {rd_en & ~out_ready, wr_en & ~in_ready};
        end
    end

    assign err = r_err;
`endif

endmodule

`default_nettype wire
